// File: rtl/apb_master_bridge.sv
// Single-outstanding request/response to APB master bridge.
// Registered APB outputs; ACCESS is bounded by TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB master
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

    state_t     state;
    logic [7:0] acc_cnt;
    logic [7:0] acc_cnt_nxt;

    assign acc_cnt_nxt = acc_cnt + 8'd1;

    // The APB address/control registers double as the latched request; they
    // are zeroed whenever the bus is idle so nothing stale leaks onto it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= SETUP;
                        req_ready <= 1'b0;
                        acc_cnt   <= '0;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        paddr     <= req_addr;
                        pwrite    <= req_write;
                        pwdata    <= req_write ? req_wdata : '0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // pready wins over a timeout landing in the same cycle
                    if (pready) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        rsp_err   <= pslverr;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        paddr     <= '0;
                        pwrite    <= 1'b0;
                        pwdata    <= '0;
                    end else if (acc_cnt_nxt == TO_LIM) begin
                        acc_cnt   <= acc_cnt_nxt;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        paddr     <= '0;
                        pwrite    <= 1'b0;
                        pwdata    <= '0;
                    end else begin
                        acc_cnt <= acc_cnt_nxt;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboarded bench for apb_master_bridge with a scripted APB slave.
module tb_apb_master_bridge;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          psel, penable, pwrite;
    logic [DW-1:0] pwdata, prdata;
    logic          pready, pslverr;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // response monitor: pops the scoreboard on each handshake
    always @(negedge clk) begin
        rsp_t e;
        #1;
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int waits, input bit serr, input logic [DW-1:0] rd, input int bp);
        rsp_t          e;
        bit            tmo;
        int            n_acc;
        int            n;
        logic [DW-1:0] exp_pw;
        tmo     = (waits >= TO);
        n_acc   = tmo ? TO : waits + 1;
        e.rdata = (tmo || wr) ? '0 : rd;
        e.err   = tmo ? 1'b1 : serr;
        exp_pw  = wr ? wd : '0;

        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_wait", req_ready, 64'd1);
            return;
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
        @(posedge clk);
        sb.push_back(e);

        @(negedge clk);
        // SETUP: keep a conflicting request asserted, it must be ignored
        req_write = ~wr; req_addr = ~a; req_wdata = ~wd;
        chk("setup_psel", psel, 64'd1);
        chk("setup_penable", penable, 64'd0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_pwdata", pwdata, exp_pw);
        chk("setup_req_ready", req_ready, 64'd0);

        for (int k = 1; k <= n_acc; k++) begin
            @(negedge clk);
            chk("acc_psel", psel, 64'd1);
            chk("acc_penable", penable, 64'd1);
            chk("acc_paddr", paddr, a);
            chk("acc_pwdata", pwdata, exp_pw);
            chk("acc_req_ready", req_ready, 64'd0);
            pready  = (!tmo && k == n_acc);
            prdata  = rd;
            pslverr = pready ? serr : 1'b1;
        end

        @(negedge clk);
        req_valid = 1'b0;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'h5A5A_5A5A;
        chk("resp_psel", psel, 64'd0);
        chk("resp_penable", penable, 64'd0);
        chk("resp_paddr", paddr, 64'd0);
        chk("resp_pwdata", pwdata, 64'd0);
        chk("resp_valid", rsp_valid, 64'd1);
        if (bp > 0) begin
            rsp_ready = 1'b0;
            repeat (bp) begin
                @(negedge clk);
                chk("bp_valid", rsp_valid, 64'd1);
                chk("bp_rdata", rsp_rdata, e.rdata);
                chk("bp_err", rsp_err, e.err);
            end
            rsp_ready = 1'b1;
        end

        @(negedge clk);
        chk("idle_req_ready", req_ready, 64'd1);
        chk("idle_rsp_valid", rsp_valid, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [DW-1:0] rw, rr;
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h3FF; req_wdata = '1;
        rsp_ready = 1'b1; prdata = '1; pready = 1'b1; pslverr = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 64'd0);
        chk("rst_rsp_valid", rsp_valid, 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", rsp_err, 64'd0);
        chk("rst_psel", psel, 64'd0);
        chk("rst_penable", penable, 64'd0);
        chk("rst_paddr", paddr, 64'd0);
        chk("rst_pwrite", pwrite, 64'd0);
        chk("rst_pwdata", pwdata, 64'd0);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", req_ready, 64'd1);

        xfer(1'b1, 10'h004, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0);   // zero-wait write
        xfer(1'b0, 10'h008, 32'h0, 3, 1'b0, 32'h12345678, 0);   // 3 waits, pready on last count
        xfer(1'b0, 10'h00C, 32'h0, 0, 1'b1, 32'hCAFE0001, 0);   // slave error
        xfer(1'b0, 10'h010, 32'h0, 20, 1'b0, 32'h77777777, 0);  // timeout read
        xfer(1'b1, 10'h014, 32'h11112222, 9, 1'b0, 32'h0, 0);   // timeout write
        xfer(1'b1, 10'h018, 32'hA5A5A5A5, 2, 1'b1, 32'hFFFF0000, 0);
        xfer(1'b0, 10'h01C, 32'h0, 1, 1'b0, 32'h0BADF00D, 5);   // response backpressure
        for (int i = 0; i < 6; i++) begin
            ra = AW'($urandom);
            rw = $urandom;
            rr = $urandom;
            xfer(1'($urandom_range(0, 1)), ra, rw, int'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)), rr, int'($urandom_range(0, 2)));
        end

        // reset in the middle of ACCESS discards the transfer
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h0AA; req_wdata = '0; pready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_penable", penable, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_psel", psel, 64'd0);
        chk("async_rst_penable", penable, 64'd0);
        chk("async_rst_rsp_valid", rsp_valid, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 64'd1);
        chk("post_rst_rsp_valid", rsp_valid, 64'd0);
        chk("post_rst_psel", psel, 64'd0);

        xfer(1'b1, 10'h020, 32'h0F0F0F0F, 0, 1'b0, 32'h0, 1);  // clean transfer after reset
        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
